// File: rtl/imm_lut_rf_pkg.sv
// Shared definitions for the immediate / lookup-table register file:
// FSM state encoding and the power-on default table contents.
package imm_lut_rf_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int unsigned DEF_DEPTH = 16;

  // Default entries 0..15, native 8-bit width.
  localparam logic [7:0] DEFAULT_TABLE [DEF_DEPTH] = '{
    8'hF1, 8'h80, 8'h81, 8'hC8, 8'h82, 8'h26, 8'hD7, 8'h40,
    8'h00, 8'hF5, 8'h80, 8'h4A, 8'hF0, 8'h00, 8'h00, 8'h00
  };

  // Default value for entry k; indices past the constant table read as zero.
  function automatic logic [7:0] default_entry(input int unsigned k);
    logic [7:0] v;
    if (k < DEF_DEPTH) begin
      v = DEFAULT_TABLE[k[3:0]];
    end else begin
      v = 8'h00;
    end
    return v;
  endfunction

endpackage

// File: rtl/imm_lut_mem.sv
// Table storage: one write port, one combinational read port with
// write-first bypass when the write and read hit the same index.
// The array has no reset; contents survive reset until rewritten.
module imm_lut_mem #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          Clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [2**AW];
  logic          w_bypass;

  // Storage write on the rising edge.
  always_ff @(posedge Clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read with write-first forwarding of same-cycle write data.
  always_comb begin
    w_bypass = i_wr_en && (i_wr_addr == i_rd_addr);
    if (w_bypass) begin
      o_rd_data = i_wr_data;
    end else begin
      o_rd_data = r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/imm_lut_rf.sv
// Immediate generator with a writable lookup table. After reset the
// table is walked once to load defaults (busy=1); afterwards each
// request returns either a table entry or an extended direct immediate
// one cycle later.
module imm_lut_rf
  import imm_lut_rf_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          rd_req,
  input  logic [AW:0]   in,
  input  logic          sext,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] datOut,
  output logic          out_valid,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;
  logic [DW-1:0] r_dat;
  logic          r_valid;

  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_data;
  logic [DW-1:0] w_init_data;
  logic [DW-1:0] w_rd_data;
  logic [DW-1:0] w_ext;
  logic [DW-1:0] w_result;

  // Default value for the entry currently being loaded, resized to DW.
  always_comb begin
    w_init_data = DW'(default_entry(32'(r_cnt)));
  end

  // Write-port mux: INIT walk owns the port, otherwise the external strobe.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = '0;
    w_mem_data = '0;
    if (r_state == ST_INIT) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_cnt;
      w_mem_data = w_init_data;
    end else begin
      w_mem_we   = wr_en;
      w_mem_addr = wr_addr;
      w_mem_data = wr_data;
    end
  end

  // Direct immediate: sign- or zero-extend the low AW bits of the request.
  always_comb begin
    w_ext = '0;
    if (sext) begin
      w_ext = {{(DW-AW){in[AW-1]}}, in[AW-1:0]};
    end else begin
      w_ext = {{(DW-AW){1'b0}}, in[AW-1:0]};
    end
  end

  // Result select: table lookup when the mode bit is set, else direct.
  always_comb begin
    w_result = '0;
    if (in[AW]) begin
      w_result = w_rd_data;
    end else begin
      w_result = w_ext;
    end
  end

  imm_lut_mem #(
    .DW(DW),
    .AW(AW)
  ) u_mem (
    .Clk       (Clk),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (w_mem_addr),
    .i_wr_data (w_mem_data),
    .i_rd_addr (in[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  // FSM, init counter and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_dat   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_valid <= 1'b0;
          if (r_cnt == LAST_IDX) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        ST_READY: begin
          if (rd_req) begin
            r_dat   <= w_result;
            r_valid <= 1'b1;
          end else begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign datOut    = r_dat;
  assign out_valid = r_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_imm_lut_rf.sv
// Directed bench for imm_lut_rf (DW=8, AW=4): reset/INIT timing, a
// table of READY-state vectors, and sequences for reset mid-burst and
// requests/writes issued during INIT.
module tb_imm_lut_rf;

  logic       Clk;
  logic       Reset_n;
  logic       rd_req;
  logic [4:0] in_s;
  logic       sext;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] datOut;
  logic       out_valid;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rd;
    logic [4:0] in;
    logic       sx;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       exp_v;
    logic [7:0] exp_d;
    string      name;
  } vec_t;

  vec_t vecs [16];

  imm_lut_rf #(.DW(8), .AW(4)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .rd_req    (rd_req),
    .in        (in_s),
    .sext      (sext),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .datOut    (datOut),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_req  = 1'b0;
    in_s    = 5'h00;
    sext    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 4'h0;
    wr_data = 8'h00;
  endtask

  // Wait (bounded) for INIT to end, checking out_valid stays low.
  task automatic wait_ready(input string name, output int busy_cycles);
    int guard;
    guard = 0;
    busy_cycles = 1;
    while (busy === 1'b1 && guard < 100) begin
      tick();
      guard++;
      chk({name, "_valid_in_init"}, {31'd0, out_valid}, 32'd0);
      if (busy === 1'b1) busy_cycles++;
    end
    if (guard >= 100) begin
      chk({name, "_timeout"}, 32'(guard), 32'd16);
    end
  endtask

  task automatic lookup(input string name, input logic [4:0] idx, input logic [7:0] exp);
    idle_inputs();
    rd_req = 1'b1;
    in_s   = idx;
    tick();
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_data"}, {24'd0, datOut}, {24'd0, exp});
    idle_inputs();
  endtask

  initial begin
    int n;

    vecs[0]  = '{1'b1, 5'h10, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'hF1, "lut_0"};
    vecs[1]  = '{1'b1, 5'h13, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'hC8, "lut_3"};
    vecs[2]  = '{1'b1, 5'h1C, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'hF0, "lut_12"};
    vecs[3]  = '{1'b0, 5'h10, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'hF0, "idle_hold"};
    vecs[4]  = '{1'b1, 5'h0B, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h0B, "dir_zext"};
    vecs[5]  = '{1'b1, 5'h0B, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 8'hFB, "dir_sext_neg"};
    vecs[6]  = '{1'b1, 5'h05, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 8'h05, "dir_sext_pos"};
    vecs[7]  = '{1'b1, 5'h13, 1'b0, 1'b1, 4'h3, 8'h5A, 1'b1, 8'h5A, "wr_first"};
    vecs[8]  = '{1'b1, 5'h13, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h5A, "wr_persist"};
    vecs[9]  = '{1'b1, 5'h19, 1'b0, 1'b1, 4'h8, 8'h77, 1'b1, 8'hF5, "wr_rd_diff"};
    vecs[10] = '{1'b1, 5'h18, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h77, "wr_diff_chk"};
    vecs[11] = '{1'b1, 5'h1F, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, "lut_15"};
    vecs[12] = '{1'b1, 5'h17, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h40, "lut_7"};
    vecs[13] = '{1'b0, 5'h00, 1'b0, 1'b1, 4'h7, 8'h11, 1'b0, 8'h40, "wr7_hold"};
    vecs[14] = '{1'b1, 5'h17, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h11, "lut_7_new"};
    vecs[15] = '{1'b1, 5'h15, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h26, "lut_5"};

    // Reset, then idle through INIT.
    idle_inputs();
    Reset_n = 1'b0;
    tick();
    tick();
    chk("rst_data",  {24'd0, datOut}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd1);
    Reset_n = 1'b1;
    wait_ready("init", n);
    chk("init_busy_cycles", 32'(n), 32'd16);

    // READY-state vector table.
    for (int i = 0; i < 16; i++) begin
      rd_req  = vecs[i].rd;
      in_s    = vecs[i].in;
      sext    = vecs[i].sx;
      wr_en   = vecs[i].we;
      wr_addr = vecs[i].wa;
      wr_data = vecs[i].wd;
      tick();
      chk({vecs[i].name, "_valid"}, {31'd0, out_valid}, {31'd0, vecs[i].exp_v});
      chk({vecs[i].name, "_data"},  {24'd0, datOut},    {24'd0, vecs[i].exp_d});
    end
    idle_inputs();
    tick();

    // Read burst at entry 7 (currently 8'h11) with reset on cycle 5.
    rd_req = 1'b1;
    in_s   = 5'h17;
    for (int c = 1; c <= 8; c++) begin
      Reset_n = (c == 5) ? 1'b0 : 1'b1;
      tick();
      if (c < 5) begin
        chk("burst_data",  {24'd0, datOut}, 32'h11);
        chk("burst_valid", {31'd0, out_valid}, 32'd1);
      end else if (c == 5) begin
        chk("burst_rst_data",  {24'd0, datOut}, 32'd0);
        chk("burst_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("burst_rst_busy",  {31'd0, busy}, 32'd1);
      end else begin
        chk("burst_init_valid", {31'd0, out_valid}, 32'd0);
      end
    end
    Reset_n = 1'b1;
    idle_inputs();
    wait_ready("reinit", n);
    lookup("after_reinit_7", 5'h17, 8'h40);

    // Requests and writes held throughout INIT must be ignored.
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    rd_req  = 1'b1;
    in_s    = 5'h13;
    wr_en   = 1'b1;
    wr_addr = 4'h3;
    wr_data = 8'h5A;
    wait_ready("init_ign", n);
    chk("init_ign_cycles", 32'(n), 32'd16);
    idle_inputs();
    lookup("init_ign_entry3", 5'h13, 8'hC8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_lut_rf.md
IMM_LUT_RF -- requirements
Module: imm_lut_rf

Interface
REQ-001 Parameter DW, default 8: data/output width in bits (DW >= AW+1).
REQ-002 Parameter AW, default 4: table index width; table depth is 2**AW.
REQ-003 Clk  input  1  the single clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-005 rd_req  input  1  read request; qualifies in and sext for one cycle.
REQ-006 in  input  AW+1  in[AW]=1 selects a table lookup at index in[AW-1:0]; in[AW]=0 selects a direct immediate in[AW-1:0].
REQ-007 sext  input  1  direct mode only: 1 sign-extends in[AW-1:0] to DW; 0 zero-extends it.
REQ-008 wr_en  input  1  table write strobe.
REQ-009 wr_addr  input  AW  table write index.
REQ-010 wr_data  input  DW  table write data.
REQ-011 datOut  output  DW  registered result.
REQ-012 out_valid  output  1  datOut holds the result of the request accepted in the previous cycle.
REQ-013 busy  output  1  table initialisation in progress; requests and writes are ignored.

Function
REQ-014 The FSM SHALL have the states INIT and READY; reset SHALL enter INIT with the init counter at 0.
REQ-015 In INIT, the block SHALL write default entry k to table[k] on each cycle, with k = counter, then increment the counter; after entry 2**AW-1 it SHALL go to READY (2**AW cycles in INIT).
REQ-016 busy SHALL be 1 exactly while in INIT.
REQ-017 In INIT, rd_req and wr_en SHALL be ignored and out_valid SHALL be 0.
REQ-018 In READY, an accepted rd_req SHALL produce datOut and out_valid=1 on the next rising edge (latency 1).
REQ-019 A cycle with no rd_req SHALL set out_valid to 0 and SHALL hold datOut at its last value.
REQ-020 Lookup mode SHALL return table[in[AW-1:0]] at full DW width.
REQ-021 Direct mode SHALL return in[AW-1:0] extended per sext; the table is not read.
REQ-022 In READY, wr_en SHALL update table[wr_addr] with wr_data at the clock edge.
REQ-023 When wr_en and a lookup hit the same index in the same cycle, the read SHALL return wr_data (write-first).
REQ-024 A write and a read to different indices in the same cycle SHALL both complete with no interaction.
REQ-025 Indices SHALL wrap naturally at AW bits; no out-of-range condition exists.
REQ-026 The table SHALL be write-only through the interface except via lookups; there SHALL be no clear other than reset.

Reset
REQ-027 Reset_n=0 at a rising edge SHALL set datOut=0, out_valid=0, busy=1, state=INIT, counter=0.
REQ-028 Reset asserted mid-INIT or mid-operation SHALL restart the full default load; prior runtime writes SHALL be lost.
REQ-029 Table contents SHALL NOT be cleared by reset directly; only the INIT walk SHALL overwrite them.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the default table constant, for AW=4, DW=8, entries 0..15 being: F1,80,81,C8,82,26,D7,40,00,F5,80,4A,F0,00,00,00 (hex).
REQ-031 For other AW or DW values, the defaults SHALL be the package constants resized to DW, with entries beyond 16 equal to 0.
REQ-032 The storage array with its write-first read SHALL be one sub-module, imm_lut_mem; the FSM and output register SHALL be in imm_lut_rf.

Verification
REQ-033 Reset, then idle -> busy=1 for exactly 16 cycles, then 0; out_valid stays 0 throughout.
REQ-034 After INIT, lookups at in=5'h10, 5'h13, 5'h1C -> datOut 8'hF1, 8'hC8, 8'hF0, each with out_valid=1 one cycle later.
REQ-035 Direct in=5'h0B with sext=0 -> 8'h0B; with sext=1 -> 8'hFB.
REQ-036 Same-cycle wr_en, wr_addr=3, wr_data=8'h5A with lookup in=5'h13 -> 8'h5A; a later lookup at 5'h13 -> 8'h5A.
REQ-037 rd_req and wr_en applied during INIT -> ignored, out_valid=0, entry 3 still 8'hC8 after INIT.
REQ-038 Write entry 7 = 8'h11, pulse Reset_n for cycle 5 of a read burst -> INIT restarts, then lookup 5'h17 -> 8'h40.
